// File: rtl/cpu_consts_pkg.sv
// cpu_consts: region nibbles, reset PC, bubble word and fetch state encoding
package cpu_consts;
  localparam logic [3:0] REGION_BIOS = 4'h4;
  localparam logic [3:0] REGION_IMEM = 4'h1;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_PC = 32'h4000_0000;
  typedef enum logic {LIVE, HELD} fetch_state_t;
endpackage

// File: rtl/fetch_region_decode.sv
// fetch_region_decode: maps PC[31:28] to a BIOS select and an out-of-region fault
module fetch_region_decode import cpu_consts::*; (
  input  logic [3:0] region,
  output logic       bios_sel,
  output logic       fetch_err
);
  assign bios_sel = region == REGION_BIOS;
  assign fetch_err = !bios_sel && region != REGION_IMEM;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: drives BIOS/IMEM addresses from PC_IF and registers the IF/ID boundary
module fetch_stage import cpu_consts::*; #(
  parameter int BIOS_AW = 12,
  parameter int IMEM_AW = 14,
  parameter logic [31:0] NOP_INSTR = cpu_consts::NOP_INSTR
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [31:0]        PC_IF,
  input  logic               STALL,
  input  logic               FLUSH,
  output logic [31:0]        PC_4,
  output logic [BIOS_AW-1:0] BIOS_ADDR,
  output logic [IMEM_AW-1:0] IMEM_ADDR,
  input  logic [31:0]        BIOS_DOUT,
  input  logic [31:0]        IMEM_DOUT,
  output logic [31:0]        ID_PC,
  output logic [31:0]        ID_PC_4,
  output logic [31:0]        ID_INSTR,
  output logic               ID_VALID,
  output logic               ID_FETCH_ERR
);
  fetch_state_t state, state_next;
  logic region_sel, fetch_err, bios_sel, pc_err;
  logic [31:0] hold_instr, dout;
  fetch_region_decode u_decode (
    .region(PC_IF[31:28]),
    .bios_sel(bios_sel),
    .fetch_err(pc_err)
  );
  assign PC_4 = PC_IF + 32'd4;
  assign BIOS_ADDR = PC_IF[BIOS_AW+1:2];
  assign IMEM_ADDR = PC_IF[IMEM_AW+1:2];
  assign ID_PC_4 = ID_PC + 32'd4;
  assign ID_FETCH_ERR = fetch_err & ID_VALID;
  assign dout = region_sel ? BIOS_DOUT : IMEM_DOUT;
  // RAM data only matches ID_PC in the cycle after capture, so a stall must latch it
  assign ID_INSTR = !ID_VALID ? NOP_INSTR : state == HELD ? hold_instr : dout;
  always_comb begin
    state_next = STALL && !FLUSH ? HELD : LIVE;
  end
  always_ff @(posedge CLK) begin
    state <= RST ? LIVE : state_next;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      ID_PC <= 32'd0;
      ID_VALID <= 1'b0;
      region_sel <= 1'b1;
      fetch_err <= 1'b0;
      hold_instr <= NOP_INSTR;
    end else if (FLUSH) begin
      ID_PC <= PC_IF;
      ID_VALID <= 1'b0;
      fetch_err <= 1'b0;
    end else if (STALL) begin
      if (state == LIVE) hold_instr <= dout;
    end else begin
      ID_PC <= PC_IF;
      ID_VALID <= 1'b1;
      region_sel <= bios_sel;
      fetch_err <= pc_err;
    end
  end
endmodule
